ahb_master_req: RTL and testbench
=================================

AHB_MASTER_REQ -- requirements
Module: ahb_master_req

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; transfers SHALL be word size only.
REQ-003 hclk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 hreset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  user command request; cmd_ready  out  1  command accepted this cycle.
REQ-006 cmd_addr  in  ADDR_W  start address (word aligned); cmd_write  in  1  1=write; cmd_burst  in  hburst_type  burst kind.
REQ-007 wr_data  in  DATA_W  write beat data; wr_ready  out  1  beat consumed this cycle.
REQ-008 rd_data  out  DATA_W  read beat data; rd_valid  out  1  rd_data valid this cycle.
REQ-009 hreq  out  1  bus request to the arbiter; hgrant  in  1  grant (already qualified with not-wait).
REQ-010 hwait  in  1  slave stall, 1 = current data phase extended.
REQ-011 haddr  out  ADDR_W; htrans  out  2; hwrite  out  1; hburst  out  hburst_type; hsize  out  3; hwdata  out  DATA_W; hrdata  in  DATA_W.

Function
REQ-012 States: IDLE, REQ, XFER, LAST; SHALL be a single registered state variable.
REQ-013 IDLE: cmd_ready=1; on cmd_valid SHALL latch addr/write/burst, load beat count limit, go to REQ.
REQ-014 Beat limit: SINGLE and INCR = 1 beat; WRAP4/INCR4 = 4; WRAP8/INCR8 = 8; WRAP16/INCR16 = 16; 4-bit beat counter counts 0..limit-1.
REQ-015 REQ: hreq=1, htrans=IDLE; on hgrant=1 SHALL drive first address phase (htrans=NONSEQ) and go to XFER.
REQ-016 hreq SHALL stay 1 from REQ entry until the cycle the last beat's address phase is accepted, then drop to 0.
REQ-017 XFER: an address phase is accepted in a cycle with hgrant=1; beats after the first SHALL use htrans=SEQ.
REQ-018 With hgrant=0 in XFER, haddr, htrans, hwrite, hburst, hwdata SHALL hold their values.
REQ-019 INCRx address step SHALL be +4; WRAPx SHALL wrap within a (4*beats)-byte aligned window, bits above the window unchanged.
REQ-020 Address of beat n+1 SHALL overlap data phase of beat n (one-stage pipeline).
REQ-021 Write: hwdata for beat n SHALL appear the cycle after beat n's address is accepted, held while hwait=1; wr_ready SHALL pulse once per beat when that data phase begins.
REQ-022 Read: rd_valid=1 with rd_data=hrdata in each cycle a read data phase completes (hwait=0); exactly one pulse per beat.
REQ-023 After the last address is accepted SHALL go to LAST with htrans=IDLE; LAST exits to IDLE when the final data phase completes with hwait=0.
REQ-024 cmd_ready SHALL be 0 in REQ, XFER, LAST; a new command is accepted only in IDLE.
REQ-025 hsize SHALL be constant 3'b010; hburst and hwrite SHALL be stable for the whole burst.
REQ-026 A 1-beat transfer SHALL go REQ -> LAST directly on grant.

Reset
REQ-027 On hreset_n=0, regardless of clock, state SHALL go to IDLE and counter to 0.
REQ-028 Reset values: hreq=0, htrans=IDLE, haddr=0, hwrite=0, hburst=SINGLE, hwdata=0, rd_valid=0, wr_ready=0, cmd_ready=1 once reset is released.
REQ-029 Reset mid-burst SHALL abandon the burst without any further beats; no partial-burst resume.

Verification
REQ-030 SINGLE write 0x100, data 0xA5A5A5A5, hgrant at cycle 3, hwait=0 -> one NONSEQ at 0x100, hwdata=0xA5A5A5A5 next cycle, hreq low after grant, back to IDLE.
REQ-031 INCR4 read 0x200, hrdata 1,2,3,4 -> haddr 0x200,0x204,0x208,0x20C as NONSEQ,SEQ,SEQ,SEQ; four rd_valid pulses carrying 1..4.
REQ-032 WRAP8 write 0x338 -> haddr 0x338,0x33C,0x320,0x324,0x328,0x32C,0x330,0x334; 8 wr_ready pulses.
REQ-033 INCR4 write with hwait=1 for 2 cycles on beat 2 (hgrant=0 those cycles) -> haddr/htrans/hwdata frozen, no extra wr_ready, burst completes with 4 beats.
REQ-034 Grant delayed 5 cycles -> hreq=1 and htrans=IDLE throughout REQ; cmd_ready=0; new cmd_valid ignored until IDLE.
REQ-035 hreset_n asserted during beat 3 of INCR8 -> outputs at reset values immediately, no further beats after release.

Source files
------------

// File: rtl/ahb_master_req_if.sv
// ahb_master_req_if: burst-kind type plus the user command port and AHB master bus of ahb_master_req.
package ahb_master_req_pkg;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_type;
  localparam logic [1:0] HT_IDLE = 2'b00, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;
endpackage

interface ahb_master_req_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import ahb_master_req_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  hburst_type        cmd_burst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              hreq;
  logic              hgrant;
  logic              hwait;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  hburst_type        hburst;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_burst, wr_data, hgrant, hwait, hrdata,
    output cmd_ready, wr_ready, rd_data, rd_valid, hreq, haddr, htrans, hwrite, hburst, hsize, hwdata
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_burst, wr_data, hgrant, hwait, hrdata,
    input  cmd_ready, wr_ready, rd_data, rd_valid, hreq, haddr, htrans, hwrite, hburst, hsize, hwdata
  );
endinterface

// File: rtl/ahb_master_req.sv
// ahb_master_req: turns one user command into a word-sized AHB burst with pipelined address/data phases.
module ahb_master_req
  import ahb_master_req_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              hclk,
  input logic              hreset_n,
  ahb_master_req_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, LAST} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  hburst_type        hburst_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              hreq_q;
  logic              dph_q;
  logic [3:0]        cnt_q;
  logic [3:0]        lim_q;
  logic              acc;
  logic              last;
  logic              wrap;
  logic [3:0]        lim;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] nxt_addr;
  // The first address phase is offered in REQ itself, so a grant there is an acceptance.
  always_comb begin
    acc = bus.hgrant && (state_q == REQ || state_q == XFER);
    last = cnt_q == lim_q;
    wrap = hburst_q inside {WRAP4, WRAP8, WRAP16};
    mask = ADDR_W'({lim_q, 2'b11});
    nxt_addr = wrap ? (haddr_q & ~mask) | ((haddr_q + ADDR_W'(4)) & mask) : haddr_q + ADDR_W'(4);
    lim = (bus.cmd_burst inside {WRAP4, INCR4}) ? 4'd3 :
          (bus.cmd_burst inside {WRAP8, INCR8}) ? 4'd7 :
          (bus.cmd_burst inside {WRAP16, INCR16}) ? 4'd15 : 4'd0;
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.wr_ready  = acc && hwrite_q;
  assign bus.rd_valid  = dph_q && !bus.hwait && !hwrite_q;
  assign bus.rd_data   = bus.hrdata;
  assign bus.hreq      = hreq_q;
  assign bus.haddr     = haddr_q;
  assign bus.htrans    = (state_q == REQ && bus.hgrant) ? HT_NONSEQ : htrans_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hburst    = hburst_q;
  assign bus.hsize     = 3'b010;
  assign bus.hwdata    = hwdata_q;
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= IDLE;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      hwrite_q <= 1'b0;
      hburst_q <= SINGLE;
      hwdata_q <= '0;
      hreq_q   <= 1'b0;
      dph_q    <= 1'b0;
      cnt_q    <= 4'd0;
      lim_q    <= 4'd0;
    end else begin
      dph_q <= acc || (dph_q && bus.hwait);
      if (state_q == IDLE && bus.cmd_valid) begin
        state_q  <= REQ;
        hreq_q   <= 1'b1;
        haddr_q  <= bus.cmd_addr;
        hwrite_q <= bus.cmd_write;
        hburst_q <= bus.cmd_burst;
        lim_q    <= lim;
        cnt_q    <= 4'd0;
      end
      if (acc) begin
        if (hwrite_q) hwdata_q <= bus.wr_data;
        if (!last) haddr_q <= nxt_addr;
        state_q  <= last ? LAST : XFER;
        htrans_q <= last ? HT_IDLE : HT_SEQ;
        hreq_q   <= !last;
        cnt_q    <= last ? 4'd0 : cnt_q + 4'd1;
      end
      if (state_q == LAST && !bus.hwait) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ahb_master_req.sv
// tb_ahb_master_req: vector table of bursts against a scoreboard of expected beats, plus grant-delay and reset corners.
module tb_ahb_master_req;
  import ahb_master_req_pkg::*;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    hburst_type  burst;
    logic [31:0] dbase;
    int          gwait;
    int          stall_after;
    int          stall_len;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ahb_master_req_if bus ();
  ahb_master_req dut (.hclk(clk), .hreset_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] a_exp[$];
  logic [1:0]  t_exp[$];
  logic [31:0] wd_exp[$];
  logic [31:0] wd_src[$];
  logic [31:0] rd_exp[$];
  logic [31:0] slv_q[$];
  logic        cur_wr = 1'b0;
  hburst_type  cur_burst = SINGLE;
  logic [31:0] cur_wd = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] slv_next = '0;
  int acc_cnt = 0, gwait = 0, stall_after = 0, stall_len = 0, stall_left = 0;
  logic tb_dph = 1'b0, tb_dph_wr = 1'b0, hreq_low_chk = 1'b0, wr_pop = 1'b0;
  logic m_acc, m_rv, m_wr;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4;
      WRAP8, INCR8:   return 8;
      WRAP16, INCR16: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [31:0] next_of(input logic [31:0] a, input hburst_type b);
    logic [31:0] sz;
    sz = 32'(beats_of(b) * 4);
    if (b inside {WRAP4, WRAP8, WRAP16}) return a - (a % sz) + ((a + 32'd4) % sz);
    return a + 32'd4;
  endfunction

  // slave: grant follows hreq unless delayed or stalled; write data and read data fed from queues
  initial forever begin
    @(posedge clk);
    #1;
    if (wr_pop && wd_src.size() > 0) void'(wd_src.pop_front());
    wr_pop = 1'b0;
    bus.wr_data = wd_src.size() > 0 ? wd_src[0] : 32'h0;
    bus.hrdata = slv_q.size() > 0 ? slv_q[0] : 32'h0;
    if (stall_left > 0) begin
      bus.hwait = 1'b1;
      bus.hgrant = 1'b0;
      stall_left--;
    end else begin
      bus.hwait = 1'b0;
      if (bus.hreq && gwait > 0) begin
        gwait--;
        bus.hgrant = 1'b0;
      end else bus.hgrant = bus.hreq;
    end
  end

  // monitor: compares each accepted beat and each data phase against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      m_acc = bus.htrans != HT_IDLE && bus.hgrant;
      m_rv = tb_dph && !tb_dph_wr && !bus.hwait;
      m_wr = m_acc && cur_wr;
      if (hreq_low_chk) begin
        check("hreq_drop", bus.hreq, 0);
        hreq_low_chk = 1'b0;
      end
      if (tb_dph && tb_dph_wr) check("hwdata", bus.hwdata, cur_wd);
      if (tb_dph && !bus.hwait) tb_dph = 1'b0;
      if (bus.rd_valid || m_rv) begin
        check("rd_valid", bus.rd_valid, m_rv);
        if (bus.rd_valid) check("rd_data", bus.rd_data, rd_exp.size() > 0 ? rd_exp.pop_front() : 32'hDEADBEEF);
      end
      if (m_rv && slv_q.size() > 0) void'(slv_q.pop_front());
      if (bus.wr_ready || m_wr) begin
        check("wr_ready", bus.wr_ready, m_wr);
        wr_pop = m_wr;
      end
      if (m_acc) begin
        if (a_exp.size() == 0) check("extra_beat", bus.htrans, HT_IDLE);
        else begin
          check("haddr", bus.haddr, a_exp.pop_front());
          check("htrans", bus.htrans, t_exp.pop_front());
          check("hreq_on", bus.hreq, 1);
          check("hwrite", bus.hwrite, cur_wr);
          check("hburst", bus.hburst, cur_burst);
          check("hsize", bus.hsize, 3'b010);
          if (a_exp.size() == 0) hreq_low_chk = 1'b1;
        end
        acc_cnt++;
        last_addr = bus.haddr;
        if (acc_cnt == stall_after) stall_left = stall_len;
        tb_dph = 1'b1;
        tb_dph_wr = cur_wr;
        if (cur_wr) cur_wd = wd_exp.size() > 0 ? wd_exp.pop_front() : 32'h0;
        else slv_q.push_back(slv_next++);
      end
    end
  end

  task automatic clear_sb();
    a_exp.delete(); t_exp.delete(); wd_exp.delete(); wd_src.delete(); rd_exp.delete(); slv_q.delete();
    tb_dph = 1'b0; hreq_low_chk = 1'b0; stall_left = 0; gwait = 0; wr_pop = 1'b0;
  endtask

  task automatic start_cmd(input vec_t v);
    logic [31:0] a;
    a = v.addr;
    cur_wr = v.wr; cur_burst = v.burst; acc_cnt = 0; gwait = v.gwait;
    stall_after = v.stall_after; stall_len = v.stall_len; slv_next = v.dbase;
    for (int i = 0; i < beats_of(v.burst); i++) begin
      a_exp.push_back(a);
      t_exp.push_back(i == 0 ? HT_NONSEQ : HT_SEQ);
      a = next_of(a, v.burst);
      if (v.wr) begin
        wd_exp.push_back(v.dbase + 32'(i));
        wd_src.push_back(v.dbase + 32'(i));
      end else rd_exp.push_back(v.dbase + 32'(i));
    end
    @(posedge clk);
    #1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_addr = v.addr; bus.cmd_write = v.wr; bus.cmd_burst = v.burst;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input vec_t v);
    int n;
    n = 0;
    while (n < 400 && !(a_exp.size() == 0 && !tb_dph && bus.cmd_ready)) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 400) check("timeout", 64'(n), 0);
    check("beats", 64'(acc_cnt), 64'(v.exp_beats));
    check("last_addr", last_addr, v.exp_last);
    check("rd_left", 64'(rd_exp.size()), 0);
    check("wd_left", 64'(wd_exp.size()), 0);
    clear_sb();
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v;
    int n;
    vecs[0] = '{32'h100, 1'b1, SINGLE, 32'hA5A5A5A5, 2, 0, 0, 1, 32'h100};
    vecs[1] = '{32'h200, 1'b0, INCR4,  32'h1,        0, 0, 0, 4, 32'h20C};
    vecs[2] = '{32'h338, 1'b1, WRAP8,  32'h1000,     0, 0, 0, 8, 32'h334};
    vecs[3] = '{32'h400, 1'b1, INCR4,  32'h2000,     0, 2, 2, 4, 32'h40C};
    vecs[4] = '{32'h50C, 1'b0, WRAP4,  32'h77,       1, 0, 0, 4, 32'h508};
    vecs[5] = '{32'h610, 1'b1, WRAP16, 32'h3000,     0, 0, 0, 16, 32'h60C};
    vecs[6] = '{32'h700, 1'b0, INCR16, 32'h100,      0, 5, 3, 16, 32'h73C};
    vecs[7] = '{32'h800, 1'b1, INCR,   32'h4000,     0, 0, 0, 1, 32'h800};
    vecs[8] = '{32'h900, 1'b0, INCR8,  32'h200,      3, 0, 0, 8, 32'h91C};
    vecs[9] = '{32'hA04, 1'b0, SINGLE, 32'h300,      0, 1, 3, 1, 32'hA04};
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0; bus.cmd_burst = SINGLE;
    repeat (2) @(posedge clk);
    #2;
    check("rst_hreq", bus.hreq, 0);
    check("rst_htrans", bus.htrans, HT_IDLE);
    check("rst_haddr", bus.haddr, 0);
    check("rst_hwrite", bus.hwrite, 0);
    check("rst_hburst", bus.hburst, SINGLE);
    check("rst_hwdata", bus.hwdata, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 10; i++) begin
      start_cmd(vecs[i]);
      wait_done(vecs[i]);
    end
    // grant held off: REQ must look idle on the bus and ignore further commands
    v = '{32'hC00, 1'b1, INCR4, 32'h5000, 5, 0, 0, 4, 32'hC0C};
    start_cmd(v);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'hFF0; bus.cmd_write = 1'b0; bus.cmd_burst = INCR16;
    repeat (4) begin
      @(negedge clk);
      check("req_hreq", bus.hreq, 1);
      check("req_htrans", bus.htrans, HT_IDLE);
      check("req_cmd_ready", bus.cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done(v);
    // reset in the middle of an INCR8 write: burst is dropped for good
    v = '{32'hB00, 1'b1, INCR8, 32'h9000, 0, 0, 0, 8, 32'hB1C};
    start_cmd(v);
    n = 0;
    while (acc_cnt < 3 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_beat3", 64'(acc_cnt), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hreq", bus.hreq, 0);
    check("mid_rst_htrans", bus.htrans, HT_IDLE);
    check("mid_rst_haddr", bus.haddr, 0);
    check("mid_rst_hwdata", bus.hwdata, 0);
    check("mid_rst_hwrite", bus.hwrite, 0);
    check("mid_rst_hburst", bus.hburst, SINGLE);
    check("mid_rst_wr_ready", bus.wr_ready, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    clear_sb();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #2;
      check("post_rst_hreq", bus.hreq, 0);
      check("post_rst_htrans", bus.htrans, HT_IDLE);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
